// File: rtl/double_shift_left_seq.sv
// double_shift_left_seq
//   Iterative double-shift-left unit. Concatenates a (upper word) and b (lower
//   word) into a 2*WIDTH-bit value, shifts it left by sa, STEP bits per cycle,
//   and returns the upper WIDTH bits. Bit 0 is the MSB on every vector.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request; sampled only while ready=1
//   a      in   WIDTH  upper word of the operand
//   b      in   WIDTH  lower word of the operand
//   sa     in   SA_W   shift amount, 0..2**SA_W-1
//   ready  out  1      idle, start will be accepted
//   done   out  1      one-cycle pulse; y valid from this cycle onward
//   y      out  WIDTH  upper WIDTH bits of ({a,b} << sa), held until next done
module double_shift_left_seq #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned SA_W  = 5,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  input  logic [0:SA_W-1]  sa,
  output logic             ready,
  output logic             done,
  output logic [0:WIDTH-1] y
);

  localparam logic [0:SA_W-1] STEP_K = SA_W'(STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [0:2*WIDTH-1]     sh_q, sh_d;
  logic [0:SA_W-1]        cnt_q, cnt_d;
  logic [0:WIDTH-1]       y_q, y_d;
  logic [0:SA_W-1]        k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    k       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_d    = {a, b};
          cnt_d   = sa;
          state_d = (sa != '0) ? S_SHIFT : S_DONE;
        end
      end

      S_SHIFT: begin
        // Clamp the step to the remaining count so cnt never wraps.
        k       = (32'(cnt_q) < STEP) ? cnt_q : STEP_K;
        sh_d    = sh_q << k;
        cnt_d   = cnt_q - k;
        if (cnt_d == '0) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Capture the result on entry to DONE so y is already valid while done=1.
    if (state_d == S_DONE) begin
      y_d = sh_d[0:WIDTH-1];
    end
  end

  assign ready = (state_q == S_IDLE);
  assign done  = (state_q == S_DONE);
  assign y     = y_q;

endmodule

// File: tb/tb_double_shift_left_seq.sv
module tb_double_shift_left_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [23:0] a;
  logic [23:0] b;
  logic [4:0]  sa;
  logic        ready;
  logic        done;
  logic [23:0] y;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];
  logic [23:0] cur_y;

  double_shift_left_seq #(
    .WIDTH(24),
    .SA_W (5),
    .STEP (1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .sa   (sa),
    .ready(ready),
    .done (done),
    .y    (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] model(input logic [23:0] ai, input logic [23:0] bi,
                                        input logic [4:0] si);
    logic [47:0] t;
    t = {ai, bi};
    t = t << si;
    return t[47:24];
  endfunction

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      logic [23:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done=1 with no operation outstanding (y=%h)", y);
      end else begin
        e = exp_q.pop_front();
        if (y !== e) begin
          errors++;
          $display("FAIL y_result: y=%h required %h", y, e);
        end
      end
    end
  end

  task automatic run_op(input logic [23:0] ai, input logic [23:0] bi, input logic [4:0] si,
                        input string name);
    logic [23:0] e;
    int n;
    e = model(ai, bi, si);
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_before: ready=%b required 1", name, ready);
    end
    a = ai; b = bi; sa = si; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 24'($urandom); b = 24'($urandom); sa = 5'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1 && done !== 1'b1) begin
        checks++;
        if (ready !== 1'b0 || y !== cur_y) begin
          errors++;
          $display("FAIL %s_busy_hold: ready=%b y=%h required ready=0 y=%h", name, ready, y, cur_y);
        end
      end
    end while (done !== 1'b1 && n < 200);
    checks++;
    if (n != 1 + int'(si)) begin
      errors++;
      $display("FAIL %s_latency: done after %0d cycles required %0d", name, n, 1 + int'(si));
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ready !== 1'b1 || y !== e) begin
      errors++;
      $display("FAIL %s_after_done: done=%b ready=%b y=%h required done=0 ready=1 y=%h",
               name, done, ready, y, e);
    end
    cur_y = e;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; sa = '0;
    cur_y = '0;
    #12;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || y !== 24'h0) begin
      errors++;
      $display("FAIL reset_state: ready=%b done=%b y=%h required 1 0 000000", ready, done, y);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || y !== 24'h0) begin
      errors++;
      $display("FAIL reset_release: ready=%b done=%b y=%h required 1 0 000000", ready, done, y);
    end
  endtask

  task automatic test_directed();
    run_op(24'h00FF0F, 24'h000FFF, 5'd5,  "sa5");
    run_op(24'h123456, 24'hABCDEF, 5'd0,  "sa0");
    run_op(24'h000001, 24'h800000, 5'd23, "sa23");
    run_op(24'h123456, 24'hABCDEF, 5'd24, "sa24");
    run_op(24'h123456, 24'hABCDEF, 5'd31, "sa31");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_op(24'($urandom), 24'($urandom), 5'($urandom_range(0, 31)), "rand");
    end
  endtask

  task automatic test_back_to_back();
    run_op(24'hFFFFFF, 24'h000000, 5'd1, "b2b_a");
    run_op(24'h000000, 24'hFFFFFF, 5'd2, "b2b_b");
    run_op(24'h5A5A5A, 24'hA5A5A5, 5'd0, "b2b_c");
  endtask

  task automatic test_ignored_start();
    logic [23:0] e;
    int n;
    int extra;
    e = model(24'hC0FFEE, 24'h135790, 5'd10);
    @(negedge clk);
    a = 24'hC0FFEE; b = 24'h135790; sa = 5'd10; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 3) begin
        a = 24'h0F0F0F; b = 24'hF0F0F0; sa = 5'd2; start = 1'b1;
      end else if (n == 4) begin
        start = 1'b0;
      end
    end while (done !== 1'b1 && n < 200);
    checks++;
    if (n != 11) begin
      errors++;
      $display("FAIL ignored_start_latency: done after %0d cycles required 11", n);
    end
    checks++;
    if (y !== e) begin
      errors++;
      $display("FAIL ignored_start_y: y=%h required %h", y, e);
    end
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL ignored_start_extra: extra done=%0d ready=%b required 0 and 1", extra, ready);
    end
    cur_y = e;
  endtask

  task automatic test_mid_reset();
    int pulses;
    @(negedge clk);
    a = 24'h876543; b = 24'h210FED; sa = 5'd20; start = 1'b1;
    exp_q.push_back(model(24'h876543, 24'h210FED, 5'd20));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || y !== 24'h0) begin
      errors++;
      $display("FAIL mid_reset_state: ready=%b done=%b y=%h required 1 0 000000", ready, done, y);
    end
    exp_q.delete();
    cur_y = '0;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL mid_reset_no_done: done pulses=%0d required 0", pulses);
    end
    run_op(24'h00FF0F, 24'h000FFF, 5'd5, "post_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignored_start();
    test_mid_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
